encoder_sequencer: RTL and testbench

- Top-level control FSM for the encoder datapath.
- For each file index in 0..num_files-1, runs NUM_ROUNDS rounds. Each round executes five stages strictly in order: colParity (CP), rotate (RO), permute (PE), revaluate (RE), addRC (RC).
- Drives file_index, iteration and the per-stage start strobes. Consumes the per-stage finish signals.
- Instantiated beside the encoder datapath inside the encoder top; the datapath's start/finish ports connect one-to-one.

---
 rtl/encoder_sequencer.sv | 84 ++++++++
 tb/tb_encoder_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_sequencer.sv
// encoder_sequencer: per-file, per-round stage sequencer driving CP/RO/PE/RE/RC start strobes
`timescale 1ns/1ps
module encoder_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int FILE_W     = 10,
    parameter int ITER_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FILE_W-1:0] num_files,
    output logic              busy,
    output logic              done,
    output logic [FILE_W-1:0] file_index,
    output logic [ITER_W-1:0] iteration,
    output logic              CP_start,
    output logic              RO_start,
    output logic              PE_start,
    output logic              RE_start,
    output logic              RC_start,
    input  logic              CP_finish,
    input  logic              RO_finish,
    input  logic              PE_finish,
    input  logic              RE_finish,
    input  logic              RC_finish
);
    typedef enum logic [3:0] {
        IDLE, CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT,
        RE_GO, RE_WAIT, RC_GO, RC_WAIT, NEXT, DONE
    } state_t;
    state_t state, state_nxt;
    logic [FILE_W-1:0] nf_q;
    logic last_iter, last_file;
    assign last_iter = iteration == ITER_W'(NUM_ROUNDS - 1);
    assign last_file = file_index == nf_q - FILE_W'(1);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ((num_files == '0) ? DONE : CP_GO) : IDLE;
            CP_GO:   state_nxt = CP_WAIT;
            CP_WAIT: state_nxt = CP_finish ? RO_GO : CP_WAIT;
            RO_GO:   state_nxt = RO_WAIT;
            RO_WAIT: state_nxt = RO_finish ? PE_GO : RO_WAIT;
            PE_GO:   state_nxt = PE_WAIT;
            PE_WAIT: state_nxt = PE_finish ? RE_GO : PE_WAIT;
            RE_GO:   state_nxt = RE_WAIT;
            RE_WAIT: state_nxt = RE_finish ? RC_GO : RE_WAIT;
            RC_GO:   state_nxt = RC_WAIT;
            RC_WAIT: state_nxt = RC_finish ? NEXT : RC_WAIT;
            NEXT:    state_nxt = (last_iter && last_file) ? DONE : CP_GO;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nf_q       <= '0;
            file_index <= '0;
            iteration  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                nf_q       <= num_files;
                file_index <= '0;
                iteration  <= '0;
            end
            if (state == NEXT && !last_iter)
                iteration <= iteration + ITER_W'(1);
            else if (state == NEXT && !last_file) begin
                file_index <= file_index + FILE_W'(1);
                iteration  <= '0;
            end
        end
    end
    // Every output is a pure state decode, so finish inputs never reach a start strobe combinationally.
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign CP_start = state == CP_GO;
    assign RO_start = state == RO_GO;
    assign PE_start = state == PE_GO;
    assign RE_start = state == RE_GO;
    assign RC_start = state == RC_GO;
endmodule

// File: tb/tb_encoder_sequencer.sv
// tb_encoder_sequencer: randomized job runs checked against a nested-loop schedule model
`timescale 1ns/1ps
module tb_encoder_sequencer;
    localparam int NR = 24;
    logic clk, rst, start, busy, done;
    logic [9:0] num_files, file_index;
    logic [4:0] iteration;
    logic [4:0] st, fin;
    int n_tests, n_fail;

    encoder_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_files(num_files),
        .busy(busy), .done(done), .file_index(file_index), .iteration(iteration),
        .CP_start(st[0]), .RO_start(st[1]), .PE_start(st[2]), .RE_start(st[3]), .RC_start(st[4]),
        .CP_finish(fin[0]), .RO_finish(fin[1]), .PE_finish(fin[2]), .RE_finish(fin[3]), .RC_finish(fin[4])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Drives one job; the model is the flat (file, round, stage) schedule plus per-stage lengths of d+1.
    task automatic run_job(input int nf, input int maxd, input bit strays, input bit re7, input bit mid, input bit do_rst);
        int qf[$], qi[$], qs[$];
        int cnt[5];
        int t, tot, fin_at, fin_s, d, s, budget, ef, ei, es;
        bit rst_pend, early, finished;
        t = 0; tot = 0; fin_at = -1; fin_s = -1; rst_pend = 0; finished = 0;
        for (int j = 0; j < 5; j++) cnt[j] = 0;
        budget = 100 + nf * NR * (5 * (maxd + 9) + 1);
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < NR; r++)
                for (int x = 0; x < 5; x++) begin
                    qf.push_back(f); qi.push_back(r); qs.push_back(x);
                end
        @(negedge clk);
        start = 1; num_files = 10'(nf); fin = '0;
        while (!finished) begin
            @(negedge clk);
            t++;
            start = mid && t >= 50 && t < 53;
            num_files = 10'($urandom);
            if (rst_pend) begin
                rst = 1; fin = '0; start = 0;
                @(negedge clk);
                rst = 0;
                n_tests++;
                if ({busy, done, st, file_index, iteration} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid: busy=%b done=%b starts=%b file=%0d iter=%0d, expected all 0", busy, done, st, file_index, iteration);
                end
                @(negedge clk);
                n_tests++;
                if (st !== '0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_after: starts=%b busy=%b, expected 00000 0", st, busy);
                end
                return;
            end
            early = 0;
            n_tests++;
            if ($countones(st) > 1) begin
                n_fail++;
                $display("FAIL onehot: starts=%b at t=%0d, expected at most one high", st, t);
            end
            s = -1;
            for (int j = 0; j < 5; j++) if (st[j] === 1'b1) s = j;
            if (s >= 0) begin
                cnt[s]++;
                n_tests++;
                if (qs.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_start: stage %0d at t=%0d, expected none", s, t);
                end else begin
                    ef = qf.pop_front(); ei = qi.pop_front(); es = qs.pop_front();
                    if (s != es || file_index !== 10'(ef) || iteration !== 5'(ei)) begin
                        n_fail++;
                        $display("FAIL sequence: stage=%0d file=%0d iter=%0d, expected stage=%0d file=%0d iter=%0d", s, file_index, iteration, es, ef, ei);
                    end
                end
                d = (re7 && s == 3) ? 7 : 1 + int'($urandom_range(0, maxd));
                if (strays && s == 2 && d < 2) d = 2;
                early = strays && d > 1 && (s == 2 || $urandom_range(0, 1) == 1);
                tot += d + 1; fin_at = t + d; fin_s = s;
                if (do_rst && s == 3 && file_index == 10'd1 && iteration == 5'd7) rst_pend = 1;
            end
            for (int j = 0; j < 5; j++) fin[j] = strays && j != fin_s && $urandom_range(0, 3) == 0;
            if (t == fin_at) fin[fin_s] = 1;
            if (early) fin[s] = 1;
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_job: busy=%b at t=%0d, expected 1", busy, t);
            end
            if (done === 1'b1) begin
                finished = 1;
                n_tests++;
                if (t != 1 + tot + nf * NR) begin
                    n_fail++;
                    $display("FAIL done_time: t=%0d, expected %0d", t, 1 + tot + nf * NR);
                end
                n_tests++;
                if (qs.size() != 0 || cnt[0] != nf * NR || cnt[1] != nf * NR || cnt[2] != nf * NR || cnt[3] != nf * NR || cnt[4] != nf * NR) begin
                    n_fail++;
                    $display("FAIL start_counts: %0d %0d %0d %0d %0d left=%0d, expected %0d each", cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], qs.size(), nf * NR);
                end
                n_tests++;
                if (file_index !== 10'(nf > 0 ? nf - 1 : 0) || iteration !== 5'(nf > 0 ? NR - 1 : 0)) begin
                    n_fail++;
                    $display("FAIL final_pos: file=%0d iter=%0d, expected file=%0d iter=%0d", file_index, iteration, nf > 0 ? nf - 1 : 0, nf > 0 ? NR - 1 : 0);
                end
                fin = '0; start = 0;
                @(negedge clk);
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL after_done: busy=%b done=%b, expected 0 0", busy, done);
                end
                repeat (20) begin
                    @(negedge clk);
                    n_tests++;
                    if (st !== '0 || busy !== 1'b0 || done !== 1'b0 || file_index !== 10'(nf > 0 ? nf - 1 : 0)) begin
                        n_fail++;
                        $display("FAIL idle_hold: starts=%b busy=%b done=%b file=%0d, expected idle with file=%0d", st, busy, done, file_index, nf > 0 ? nf - 1 : 0);
                    end
                end
            end else if (t > budget) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: no done after %0d cycles", t);
                finished = 1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; start = 0; num_files = '0; fin = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, st, file_index, iteration} !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b starts=%b file=%0d iter=%0d, expected all 0", busy, done, st, file_index, iteration);
        end
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (st !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: starts=%b busy=%b, expected 00000 0", st, busy);
            end
        end
    endtask

    task automatic test_single_file;      run_job(1, 0, 0, 0, 0, 0); endtask
    task automatic test_multi_file;       run_job(3, 0, 0, 0, 0, 0); endtask
    task automatic test_zero_files;       run_job(0, 0, 0, 0, 0, 0); endtask
    task automatic test_stalls_strays;    run_job(2, 3, 1, 1, 0, 0); endtask
    task automatic test_start_while_busy; run_job(2, 1, 0, 0, 1, 0); endtask

    task automatic test_reset_mid;
        run_job(2, 0, 0, 0, 0, 1);
        run_job(1, 2, 1, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++)
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        test_reset;
        test_single_file;
        test_multi_file;
        test_zero_files;
        test_stalls_strays;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
